// File: rtl/md_sched_if.sv
// md_sched_if: pipeline-side bundle for the multiply/divide scheduler.
// Optional macro MD_CANCEL_EN adds the cancel signal.
interface md_sched_if;
    logic        start;
    logic [1:0]  m_or_d;
    logic [31:0] A;
    logic [31:0] B;
    logic        HI_write;
    logic        LO_write;
    logic        md_use;
`ifdef MD_CANCEL_EN
    logic        cancel;
`endif
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline side: issues operations and observes HI/LO.
    modport master (
        output start, m_or_d, A, B, HI_write, LO_write, md_use,
`ifdef MD_CANCEL_EN
        output cancel,
`endif
        input  busy, stall, done, HI, LO
    );

    // Scheduler side.
    modport slave (
        input  start, m_or_d, A, B, HI_write, LO_write, md_use,
`ifdef MD_CANCEL_EN
        input  cancel,
`endif
        output busy, stall, done, HI, LO
    );
endinterface

// File: rtl/md_sched.sv
// md_sched: multi-cycle mult/multu/div/divu scheduler owning the HI/LO registers.
// The result is computed when the operation is accepted and committed after a
// fixed latency (5 cycles multiply, 10 cycles divide).
// Optional macro MD_CANCEL_EN adds a cancel input that aborts an operation.
module md_sched (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  bus
);
    localparam int unsigned DW      = 32;
    localparam int unsigned CW      = 4;
    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [DW-1:0] res_hi_q, res_hi_d;
    logic [DW-1:0] res_lo_q, res_lo_d;

    logic          cancel;
`ifdef MD_CANCEL_EN
    assign cancel = bus.cancel;
`else
    assign cancel = 1'b0;
`endif

    // Arithmetic datapath, evaluated on the operands presented with start.
    logic signed [2*DW-1:0] a_sx, b_sx, prod_s;
    logic        [2*DW-1:0] prod_u;
    logic signed [DW-1:0]   a_s, b_s, quo_s, rem_s;
    logic        [DW-1:0]   quo_u, rem_u;
    logic        [DW-1:0]   new_hi, new_lo;

    // Select the 64-bit result for the requested operation; divide by zero keeps HI/LO.
    always_comb begin
        a_sx   = {{DW{bus.A[DW-1]}}, bus.A};
        b_sx   = {{DW{bus.B[DW-1]}}, bus.B};
        prod_s = a_sx * b_sx;
        prod_u = {{DW{1'b0}}, bus.A} * {{DW{1'b0}}, bus.B};
        a_s    = bus.A;
        b_s    = bus.B;
        quo_s  = a_s / b_s;
        rem_s  = a_s % b_s;
        quo_u  = bus.A / bus.B;
        rem_u  = bus.A % bus.B;
        new_hi = hi_q;
        new_lo = lo_q;
        case (bus.m_or_d)
            2'b00: begin new_hi = prod_s[2*DW-1:DW]; new_lo = prod_s[DW-1:0]; end
            2'b01: begin new_hi = prod_u[2*DW-1:DW]; new_lo = prod_u[DW-1:0]; end
            2'b10: if (bus.B != '0) begin new_hi = rem_s; new_lo = quo_s; end
            default: if (bus.B != '0) begin new_hi = rem_u; new_lo = quo_u; end
        endcase
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        case (state_q)
            IDLE: begin
                if (!cancel) begin
                    if (bus.start) begin
                        res_hi_d = new_hi;
                        res_lo_d = new_lo;
                        busy_d   = 1'b1;
                        if (bus.m_or_d[1]) begin
                            state_d = DIV;
                            count_d = CW'(DIV_LAT);
                        end else begin
                            state_d = MUL;
                            count_d = CW'(MUL_LAT);
                        end
                    end else begin
                        if (bus.HI_write) hi_d = bus.A;
                        if (bus.LO_write) lo_d = bus.A;
                    end
                end
            end
            MUL, DIV: begin
                if (cancel) begin
                    state_d = IDLE;
                    count_d = '0;
                    busy_d  = 1'b0;
                end else if (count_q == CW'(1)) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    state_d = IDLE;
                    count_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and architectural registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    // D-stage freeze must react in the same cycle an operation is issued.
    assign bus.stall = bus.md_use & (busy_q | bus.start);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched.
module tb_md_sched;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   n;

    md_sched_if bus ();

    md_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, then count busy cycles (bounded) until it ends.
    task automatic do_op(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b,
                         input int exp_cycles, input string tag);
        bus.m_or_d = md;
        bus.A      = a;
        bus.B      = b;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            check({tag, "_nodone_busy"}, 64'(bus.done), 64'd0);
            n++;
            tick();
        end
        check({tag, "_busy_len"}, 64'(n), 64'(exp_cycles));
        check({tag, "_done"}, 64'(bus.done), 64'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.start    = 1'b0;
        bus.m_or_d   = 2'b00;
        bus.A        = '0;
        bus.B        = '0;
        bus.HI_write = 1'b0;
        bus.LO_write = 1'b0;
        bus.md_use   = 1'b0;
`ifdef MD_CANCEL_EN
        bus.cancel   = 1'b0;
`endif
        reset = 1'b0;
        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi",   64'(bus.HI),   64'd0);
        check("rst_lo",   64'(bus.LO),   64'd0);
        reset = 1'b1;
        tick();

        // mult -1 * 2
        do_op(2'b00, 32'hFFFF_FFFF, 32'd2, 5, "mult");
        check("mult_hi", 64'(bus.HI), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.LO), 64'hFFFF_FFFE);
        tick();
        check("mult_done_once", 64'(bus.done), 64'd0);

        // multu 0xFFFFFFFF * 2
        do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 5, "multu");
        check("multu_hi", 64'(bus.HI), 64'h1);
        check("multu_lo", 64'(bus.LO), 64'hFFFF_FFFE);
        tick();

        // div -7 / 2
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 10, "div");
        check("div_lo", 64'(bus.LO), 64'hFFFF_FFFD);
        check("div_hi", 64'(bus.HI), 64'hFFFF_FFFF);
        tick();

        // divu by zero leaves HI/LO intact
        do_op(2'b11, 32'd7, 32'd0, 10, "divu0");
        check("divu0_lo", 64'(bus.LO), 64'hFFFF_FFFD);
        check("divu0_hi", 64'(bus.HI), 64'hFFFF_FFFF);
        tick();

        // mthi / mtlo
        bus.A = 32'h1234_5678;
        bus.HI_write = 1'b1;
        tick();
        bus.HI_write = 1'b0;
        check("mthi_hi", 64'(bus.HI), 64'h1234_5678);
        check("mthi_lo_kept", 64'(bus.LO), 64'hFFFF_FFFD);
        bus.LO_write = 1'b1;
        tick();
        bus.LO_write = 1'b0;
        check("mtlo_lo", 64'(bus.LO), 64'h1234_5678);

        // divu 100/7 with mflo waiting in D
        bus.md_use = 1'b1;
        bus.m_or_d = 2'b11;
        bus.A = 32'd100;
        bus.B = 32'd7;
        bus.start = 1'b1;
        #1;
        check("stall_start", 64'(bus.stall), 64'd1);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stall_busy", 64'(bus.stall), 64'd1);
            check("busy_div", 64'(bus.busy), 64'd1);
            tick();
        end
        #1;
        check("stall_done", 64'(bus.stall), 64'd0);
        check("mflo_done", 64'(bus.done), 64'd1);
        check("mflo_lo", 64'(bus.LO), 64'd14);
        check("mflo_hi", 64'(bus.HI), 64'd2);
        bus.md_use = 1'b0;
        tick();

        // reset in busy cycle 3 of a mult
        bus.A = 32'h1234_5678;
        bus.HI_write = 1'b1;
        bus.LO_write = 1'b1;
        tick();
        bus.HI_write = 1'b0;
        bus.LO_write = 1'b0;
        check("pre_hi", 64'(bus.HI), 64'h1234_5678);
        check("pre_lo", 64'(bus.LO), 64'h1234_5678);
        bus.m_or_d = 2'b00;
        bus.A = 32'd3;
        bus.B = 32'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_hi", 64'(bus.HI), 64'd0);
        check("midrst_lo", 64'(bus.LO), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("postrst_nodone", 64'(bus.done), 64'd0);
            check("postrst_lo", 64'(bus.LO), 64'd0);
        end

        // start beats HI_write; then back-to-back issue in the done cycle
        bus.HI_write = 1'b1;
        do_op(2'b00, 32'h55, 32'hFFFF_FFFF, 5, "prio");
        bus.HI_write = 1'b0;
        check("prio_hi", 64'(bus.HI), 64'hFFFF_FFFF);
        check("prio_lo", 64'(bus.LO), 64'hFFFF_FFAB);
        do_op(2'b01, 32'd6, 32'd7, 5, "b2b");
        check("b2b_hi", 64'(bus.HI), 64'd0);
        check("b2b_lo", 64'(bus.LO), 64'd42);
        tick();
        check("b2b_done_once", 64'(bus.done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
